// File: rtl/uart_loader_if.sv
// Byte-stream and memory-port signal bundle for uart_loader.
interface uart_loader_if #(
  parameter int ADDR_W = 16
);
  logic              rx_vld;
  logic [7:0]        rx_data;
  logic              tx_vld;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;

  modport slave (
    input  rx_vld, rx_data, tx_busy,
    output tx_vld, tx_data, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output rx_vld, rx_data, tx_busy,
    input  tx_vld, tx_data, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/uart_loader.sv
// Host frame decoder: UART bytes -> 32-bit memory writes plus a one-byte status reply.
// Optional trailing XOR checksum byte is compiled in with UART_LOADER_CSUM_EN.
module uart_loader #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  uart_loader_if.slave bus
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] SOF       = 8'hA5;
  localparam logic [7:0] CMD_PING  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_UNK   = 8'h3F;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_LO, ADDR_HI, LEN, DATA,
`ifdef UART_LOADER_CSUM_EN
    CSUM,
`endif
    RESP
  } state_t;

`ifdef UART_LOADER_CSUM_EN
  localparam state_t POST_ST = CSUM;
  localparam logic [7:0] RSP_NAK = 8'h15;
`else
  localparam state_t POST_ST = RESP;
`endif

  state_t            state, state_nxt;
  logic [7:0]        cmd_q, cmd_nxt;
  logic [7:0]        len_q, len_nxt;
  logic [7:0]        wcnt_q, wcnt_nxt;
  logic [15:0]       addr_q, addr_nxt;
  logic [1:0]        bidx_q, bidx_nxt;
  logic [23:0]       wbuf_q, wbuf_nxt;
  logic [TW-1:0]     tmr_q, tmr_nxt;
  logic              tx_vld_q, tx_vld_nxt;
  logic [7:0]        tx_data_q, tx_data_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [31:0]       mem_wdata_q, mem_wdata_nxt;
  logic              busy_q, busy_nxt;
  logic [ADDR_W-1:0] base;
  logic              active;
  logic              tx_acc;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_nxt;
`endif

  generate
    if (ADDR_W > 16) begin : g_ext
      assign base = {{(ADDR_W-16){1'b0}}, addr_q};
    end else begin : g_trunc
      assign base = addr_q[ADDR_W-1:0];
    end
  endgenerate

  assign active = (state != IDLE) && (state != RESP);
  assign tx_acc = tx_vld_q & ~bus.tx_busy;

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd_q;
    len_nxt       = len_q;
    wcnt_nxt      = wcnt_q;
    addr_nxt      = addr_q;
    bidx_nxt      = bidx_q;
    wbuf_nxt      = wbuf_q;
    tmr_nxt       = tmr_q;
    tx_data_nxt   = tx_data_q;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
`ifdef UART_LOADER_CSUM_EN
    csum_nxt      = csum_q;
`endif

    if (active) begin
      if (bus.rx_vld)
        tmr_nxt = TMR_LOAD;
      else if (tmr_q != '0)
        tmr_nxt = tmr_q - 1'b1;
    end

    case (state)
      IDLE: if (bus.rx_vld && bus.rx_data == SOF) begin
        state_nxt = CMD;
        tmr_nxt   = TMR_LOAD;
        bidx_nxt  = 2'd0;
        wcnt_nxt  = 8'd0;
      end
      CMD: if (bus.rx_vld) begin
        cmd_nxt = bus.rx_data;
`ifdef UART_LOADER_CSUM_EN
        csum_nxt = bus.rx_data;
`endif
        if (bus.rx_data == CMD_PING || bus.rx_data == CMD_WRITE) begin
          state_nxt = ADDR_LO;
        end else begin
          state_nxt   = RESP;
          tx_data_nxt = RSP_UNK;
        end
      end
      ADDR_LO: if (bus.rx_vld) begin
        addr_nxt[7:0] = bus.rx_data;
        state_nxt     = ADDR_HI;
      end
      ADDR_HI: if (bus.rx_vld) begin
        addr_nxt[15:8] = bus.rx_data;
        state_nxt      = LEN;
      end
      LEN: if (bus.rx_vld) begin
        len_nxt = bus.rx_data;
        if (bus.rx_data != 8'd0) begin
          state_nxt = DATA;
        end else begin
          state_nxt   = POST_ST;
          tx_data_nxt = RSP_ACK;
        end
      end
      DATA: if (bus.rx_vld) begin
        bidx_nxt = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          if (cmd_q == CMD_WRITE) begin
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = base + ADDR_W'(wcnt_q);
            mem_wdata_nxt = {bus.rx_data, wbuf_q};
          end
          wcnt_nxt = wcnt_q + 8'd1;
          if (wcnt_q == len_q - 8'd1) begin
            state_nxt   = POST_ST;
            tx_data_nxt = RSP_ACK;
          end
        end else begin
          wbuf_nxt[8*bidx_q +: 8] = bus.rx_data;
        end
      end
`ifdef UART_LOADER_CSUM_EN
      CSUM: if (bus.rx_vld) begin
        state_nxt   = RESP;
        tx_data_nxt = (csum_q == bus.rx_data) ? RSP_ACK : RSP_NAK;
      end
`endif
      RESP: if (tx_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

`ifdef UART_LOADER_CSUM_EN
    if (bus.rx_vld && state inside {ADDR_LO, ADDR_HI, LEN, DATA})
      csum_nxt = csum_q ^ bus.rx_data;
`endif

    // An arriving byte beats a simultaneous expiry.
    if (active && !bus.rx_vld && tmr_q == '0)
      state_nxt = IDLE;

    tx_vld_nxt = (state_nxt == RESP);
    busy_nxt   = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      bidx_q      <= '0;
      wbuf_q      <= '0;
      tmr_q       <= '0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cmd_q       <= cmd_nxt;
      len_q       <= len_nxt;
      wcnt_q      <= wcnt_nxt;
      addr_q      <= addr_nxt;
      bidx_q      <= bidx_nxt;
      wbuf_q      <= wbuf_nxt;
      tmr_q       <= tmr_nxt;
      tx_vld_q    <= tx_vld_nxt;
      tx_data_q   <= tx_data_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      busy_q      <= busy_nxt;
`ifdef UART_LOADER_CSUM_EN
      csum_q      <= csum_nxt;
`endif
    end
  end

  assign bus.tx_vld    = tx_vld_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
endmodule
